// File: rtl/fft64_twiddle_sched.sv
// Twiddle scheduler between the two radix-8 butterfly stages of a 64-point FFT.
// For each accepted sample it computes k = idx[5:3]*idx[2:0], drives the
// shared constant-twiddle multiplier bank, waits MUL_LAT cycles, captures
// the product and hands it downstream with valid/ready. Samples with k==0
// skip the bank entirely.
module fft64_twiddle_sched #(
  parameter int MUL_LAT = 2,   // bank latency, 1..15
  parameter int W       = 10   // signed sample width (re and im each)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_re_i,
  input  logic [W-1:0] in_im_i,
  input  logic         in_sof_i,
  output logic [W-1:0] mul_re_o,
  output logic [W-1:0] mul_im_o,
  output logic [5:0]   mul_sel_o,
  input  logic [W-1:0] mul_res_re_i,
  input  logic [W-1:0] mul_res_im_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_re_o,
  output logic [W-1:0] out_im_o,
  output logic [5:0]   out_idx_o,
  output logic         out_eof_o,
  output logic         err_sof_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, OUT = 2'd2} state_e;

  state_e       state_q, state_d;
  logic [5:0]   cnt_q;
  logic [5:0]   idx_q;
  logic [3:0]   wcnt_q;
  logic [W-1:0] mul_re_q, mul_im_q;
  logic [5:0]   mul_sel_q;
  logic [W-1:0] out_re_q, out_im_q;
  logic         err_q;

  logic         accept;
  logic [5:0]   idx_d;
  logic [5:0]   k_d;
  logic         wdone;

  // Frame index and twiddle exponent of the sample being offered.
  always_comb begin
    accept = (state_q == IDLE) && in_valid_i;
    idx_d  = in_sof_i ? 6'd0 : cnt_q;
    k_d    = {3'b000, idx_d[5:3]} * {3'b000, idx_d[2:0]};
    wdone  = (wcnt_q == 4'd1);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: bypass straight to OUT when k==0, otherwise wait on the bank.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid_i) state_d = (k_d == 6'd0) ? OUT : WAIT;
      WAIT:    if (wdone)      state_d = OUT;
      OUT:     if (out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    in_ready_o  = (state_q == IDLE);
    out_valid_o = (state_q == OUT);
    out_eof_o   = (state_q == OUT) && (idx_q == 6'd63);
  end

  // Datapath: frame counter, operand latch, wait counter, result capture.
  // Bank operands only load for k!=0 so they keep their last values while
  // bypassed samples pass through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      wcnt_q    <= '0;
      mul_re_q  <= '0;
      mul_im_q  <= '0;
      mul_sel_q <= '0;
      out_re_q  <= '0;
      out_im_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= accept && in_sof_i && (cnt_q != 6'd0);
      if (accept) begin
        cnt_q <= idx_d + 6'd1;
        idx_q <= idx_d;
        if (k_d == 6'd0) begin
          out_re_q <= in_re_i;
          out_im_q <= in_im_i;
        end else begin
          mul_re_q  <= in_re_i;
          mul_im_q  <= in_im_i;
          mul_sel_q <= k_d;
          wcnt_q    <= 4'(MUL_LAT);
        end
      end else if (state_q == WAIT) begin
        wcnt_q <= wcnt_q - 4'd1;
        if (wdone) begin
          out_re_q <= mul_res_re_i;
          out_im_q <= mul_res_im_i;
        end
      end
    end
  end

  assign mul_re_o  = mul_re_q;
  assign mul_im_o  = mul_im_q;
  assign mul_sel_o = mul_sel_q;
  assign out_re_o  = out_re_q;
  assign out_im_o  = out_im_q;
  assign out_idx_o = idx_q;
  assign err_sof_o = err_q;

endmodule

// File: tb/tb_fft64_twiddle_sched.sv
// Directed bench for fft64_twiddle_sched with a toy multiplier bank:
// res_re = mul_re + mul_sel, res_im = mul_im - mul_sel.
module tb_fft64_twiddle_sched;
  localparam int W       = 10;
  localparam int MUL_LAT = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid, in_ready, in_sof;
  logic [W-1:0] in_re, in_im;
  logic [W-1:0] mul_re, mul_im, res_re, res_im;
  logic [5:0]   mul_sel;
  logic         out_valid, out_ready, out_eof, err_sof;
  logic [W-1:0] out_re, out_im;
  logic [5:0]   out_idx;

  int checks   = 0;
  int errors   = 0;
  int err_seen = 0;
  int exp_cnt  = 0;

  always #5 clk = ~clk;

  fft64_twiddle_sched #(.MUL_LAT(MUL_LAT), .W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_re_i(in_re), .in_im_i(in_im), .in_sof_i(in_sof),
    .mul_re_o(mul_re), .mul_im_o(mul_im), .mul_sel_o(mul_sel),
    .mul_res_re_i(res_re), .mul_res_im_i(res_im),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_re_o(out_re), .out_im_o(out_im), .out_idx_o(out_idx),
    .out_eof_o(out_eof), .err_sof_o(err_sof)
  );

  // Bank: operands stable after edge T, one register here, and the block's
  // capture at edge T+2 gives the two-cycle latency.
  always @(posedge clk) begin
    res_re <= mul_re + {4'b0, mul_sel};
    res_im <= mul_im - {4'b0, mul_sel};
  end

  always @(negedge clk) if (err_sof) err_seen++;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int kof(input int idx);
    return (idx >> 3) * (idx & 7);
  endfunction

  // One sample end to end; hold>0 keeps out_ready low that many extra cycles.
  task automatic xfer(input int re, input int im, input bit sof, input int hold);
    int idx, k, lat;
    bit exp_err;
    exp_err = sof && (exp_cnt != 0);
    idx     = sof ? 0 : exp_cnt;
    exp_cnt = (idx + 1) % 64;
    k       = kof(idx);
    lat = 0;
    while (!in_ready && lat < 40) begin @(negedge clk); lat++; end
    chk("in_ready_before", int'(in_ready), 1);
    in_valid  = 1'b1;
    in_re     = re[W-1:0];
    in_im     = im[W-1:0];
    in_sof    = sof;
    out_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    chk("err_sof", int'(err_sof), int'(exp_err));
    lat = 1;
    while (!out_valid && lat < 40) begin
      chk("mul_sel_wait", int'(mul_sel), k);
      chk("mul_re_wait", int'($signed(mul_re)), re);
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, (k == 0) ? 1 : MUL_LAT + 1);
    chk("out_re", int'($signed(out_re)), re + k);
    chk("out_im", int'($signed(out_im)), im - k);
    chk("out_idx", int'(out_idx), idx);
    chk("out_eof", int'(out_eof), int'(idx == 63));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_re", int'($signed(out_re)), re + k);
      chk("bp_in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", int'(in_ready), 1);
    chk("rel_valid", int'(out_valid), 0);
    chk("err_clear", int'(err_sof), 0);
  endtask

  initial begin
    in_valid = 1'b0; in_sof = 1'b0; in_re = '0; in_im = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_mul_sel", int'(mul_sel), 0);
    chk("rst_mul_re", int'(mul_re), 0);
    chk("rst_out_idx", int'(out_idx), 0);
    chk("rst_err", int'(err_sof), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full frame: idx 9 -> (101,-1), idx 63 -> (149,-49) with eof.
    for (int i = 0; i < 64; i++) xfer(100, 0, i == 0, 0);
    chk("no_err_frame", err_seen, 0);

    // Wrap without sof, then backpressure on idx 9 for 10 cycles.
    for (int i = 0; i < 9; i++) xfer(100, 0, 1'b0, 0);
    xfer(100, 0, 1'b0, 10);

    // Misalignment: idx 10..14, then sof on the 6th -> idx 0 and err pulse.
    for (int i = 0; i < 5; i++) xfer(100, 0, 1'b0, 0);
    xfer(100, 0, 1'b1, 0);
    xfer(100, 0, 1'b0, 0);
    chk("err_once", err_seen, 1);

    // Advance to idx 9 and reset it mid-wait.
    for (int i = 0; i < 7; i++) xfer(100, 0, 1'b0, 0);
    in_valid = 1'b1; in_re = 10'd50; in_im = 10'd5;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("wait_sel", int'(mul_sel), 1);
    chk("wait_valid", int'(out_valid), 0);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", int'(in_ready), 1);
    chk("arst_valid", int'(out_valid), 0);
    chk("arst_mul_sel", int'(mul_sel), 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("discarded_valid", int'(out_valid), 0);
    end
    xfer(7, -3, 1'b0, 0);
    xfer(20, 4, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
